// File: rtl/csi2_rx_packet_parser.sv
// CSI-2 receive packet parser for loopback/self-test of the camera link.
// Takes a lane-merged 32-bit byte stream (byte0 = s_data[7:0] first on wire),
// parses short/long packet headers, checks header ECC, and forwards the payload
// of the selected VC/DT as a push-only pixel stream with SOF (tuser) and EOL (tlast).
//
// Ports:
//   clk_100M, reset          clock, asynchronous active-high reset
//   s_data/s_valid/s_sot     input byte stream, s_sot marks a packet header word
//   status_clr               pulse clearing the sticky error flags
//   m_axis_*                 registered payload stream, no backpressure
//   frame_active             high between FS and FE
//   frame_count/line_count   FE count (wrapping) and lines completed in frame
//   ecc_err/len_err/crc_err  sticky error flags
//
// Optional feature macro: CSI2_RX_CRC_CHECK_EN enables payload CRC-16 checking;
// when undefined the CRC word is consumed unchecked and crc_err is tied low.
module csi2_rx_packet_parser #(
  parameter logic [1:0]  VC_SEL = 2'd0,
  parameter logic [5:0]  DT_SEL = 6'h24,
  parameter logic [15:0] MAX_WC = 16'd7680
) (
  input  logic        clk_100M,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_sot,
  input  logic        status_clr,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        frame_active,
  output logic [15:0] frame_count,
  output logic [15:0] line_count,
  output logic        ecc_err,
  output logic        len_err,
  output logic        crc_err
);

  typedef enum logic [2:0] {StIdle, StPayload, StSkip, StCrc, StDrop} state_e;

  // Parity masks over header bits [23:0] for the six CSI-2 ECC bits.
  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  state_e      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic        sof_q, sof_d;
  logic        fa_q, fa_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] lc_q, lc_d;
  logic        ecc_err_q, ecc_err_d;
  logic        len_err_q, len_err_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;

  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic        ecc_ok;

  assign vc     = s_data[7:6];
  assign dt     = s_data[5:0];
  assign wc     = s_data[23:8];
  assign ecc_ok = (s_data[31:24] == {2'b00, ecc_calc(s_data[23:0])});

`ifdef CSI2_RX_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_err_q, crc_err_d;

  // Reflected CRC-16 (0x1021 -> 0x8408), byte0 first, LSB first within each byte.
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 32; i++) begin
      if (r[0] ^ w[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sof_d     = sof_q;
    fa_d      = fa_q;
    fc_d      = fc_q;
    lc_d      = lc_q;
    // Clear first so a same-cycle error set below takes priority.
    ecc_err_d = status_clr ? 1'b0 : ecc_err_q;
    len_err_d = status_clr ? 1'b0 : len_err_q;
    tdata_d   = '0;
    tvalid_d  = 1'b0;
    tuser_d   = 1'b0;
    tlast_d   = 1'b0;
`ifdef CSI2_RX_CRC_CHECK_EN
    crc_d     = crc_q;
    crc_err_d = status_clr ? 1'b0 : crc_err_q;
`endif

    if (s_valid && s_sot) begin
      // A header in any state starts a new packet; mid-packet it is a truncation.
      if (state_q == StPayload || state_q == StSkip || state_q == StCrc) len_err_d = 1'b1;
      state_d = StIdle;
`ifdef CSI2_RX_CRC_CHECK_EN
      crc_d = 16'hFFFF;
`endif
      if (!ecc_ok) begin
        ecc_err_d = 1'b1;
        state_d   = StDrop;
      end else if (dt <= 6'h0F) begin
        if (vc == VC_SEL && dt == 6'h00) begin
          fa_d  = 1'b1;
          lc_d  = '0;
          sof_d = 1'b1;
        end else if (vc == VC_SEL && dt == 6'h01) begin
          fa_d = 1'b0;
          fc_d = fc_q + 16'd1;
        end
      end else if (wc > MAX_WC || wc[1:0] != 2'b00) begin
        len_err_d = 1'b1;
        state_d   = StDrop;
      end else if (wc == 16'd0) begin
        state_d = StCrc;
      end else begin
        cnt_d   = wc[15:2];
        state_d = (vc == VC_SEL && dt == DT_SEL) ? StPayload : StSkip;
      end
    end else if (s_valid) begin
      unique case (state_q)
        StPayload, StSkip: begin
          cnt_d = cnt_q - 14'd1;
`ifdef CSI2_RX_CRC_CHECK_EN
          crc_d = crc_word(crc_q, s_data);
`endif
          if (state_q == StPayload) begin
            tvalid_d = 1'b1;
            tdata_d  = s_data;
            tuser_d  = sof_q;
            sof_d    = 1'b0;
            if (cnt_q == 14'd1) begin
              tlast_d = 1'b1;
              lc_d    = lc_q + 16'd1;
            end
          end
          if (cnt_q == 14'd1) state_d = StCrc;
        end
        StCrc: begin
`ifdef CSI2_RX_CRC_CHECK_EN
          if (s_data[15:0] != crc_q) crc_err_d = 1'b1;
`endif
          state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sof_q     <= 1'b0;
      fa_q      <= 1'b0;
      fc_q      <= '0;
      lc_q      <= '0;
      ecc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sof_q     <= sof_d;
      fa_q      <= fa_d;
      fc_q      <= fc_d;
      lc_q      <= lc_d;
      ecc_err_q <= ecc_err_d;
      len_err_q <= len_err_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tuser_q   <= tuser_d;
      tlast_q   <= tlast_d;
    end
  end

`ifdef CSI2_RX_CRC_CHECK_EN
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      crc_q     <= 16'hFFFF;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_err_q <= crc_err_d;
    end
  end
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_active  = fa_q;
  assign frame_count   = fc_q;
  assign line_count    = lc_q;
  assign ecc_err       = ecc_err_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_csi2_rx_packet_parser.sv
module tb_csi2_rx_packet_parser;

  logic        clk_100M = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_sot = 1'b0;
  logic        status_clr = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic        frame_active;
  logic [15:0] frame_count, line_count;
  logic        ecc_err, len_err, crc_err;

  csi2_rx_packet_parser dut (
    .clk_100M      (clk_100M),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_sot         (s_sot),
    .status_clr    (status_clr),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_active  (frame_active),
    .frame_count   (frame_count),
    .line_count    (line_count),
    .ecc_err       (ecc_err),
    .len_err       (len_err),
    .crc_err       (crc_err)
  );

  always #5 clk_100M = ~clk_100M;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
    logic [31:0] tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  logic [15:0] tb_crc = 16'hFFFF;

`ifdef CSI2_RX_CRC_CHECK_EN
  localparam logic EXP_CRC_BAD = 1'b1;
`else
  localparam logic EXP_CRC_BAD = 1'b0;
`endif

  always @(posedge clk_100M) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CSI-2 header ECC written out as the parity equations.
  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [7:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    p[7:6] = 2'b00;
    return p;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                      input logic [15:0] wc);
    logic [23:0] d;
    d = {wc, vc, dt};
    return {ecc_of(d), d};
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    r = crc_byte(c, w[7:0]);
    r = crc_byte(r, w[15:8]);
    r = crc_byte(r, w[23:16]);
    r = crc_byte(r, w[31:24]);
    return r;
  endfunction

  task automatic drive(input logic [31:0] d, input logic sot, input int gap);
    repeat (gap) begin
      @(posedge clk_100M); #2;
      s_valid = 1'b0;
      s_sot   = 1'b0;
    end
    @(posedge clk_100M); #2;
    s_data  = d;
    s_valid = 1'b1;
    s_sot   = sot;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_100M); #2;
      s_valid = 1'b0;
      s_sot   = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [31:0] h, input int gap);
    drive(h, 1'b1, gap);
    tb_crc = 16'hFFFF;
  endtask

  task automatic send_pay(input logic [31:0] d, input logic u, input logic l, input int gap);
    drive(d, 1'b0, gap);
    sb.push_back('{d: d, u: u, l: l, tag: cyc + 1});
    tb_crc = crc_upd(tb_crc, d);
  endtask

  task automatic send_skip(input logic [31:0] d, input int gap);
    drive(d, 1'b0, gap);
    tb_crc = crc_upd(tb_crc, d);
  endtask

  task automatic send_crc(input logic [15:0] corrupt, input int gap);
    drive({16'hA5A5, tb_crc ^ corrupt}, 1'b0, gap);
  endtask

  task automatic clear_flags();
    @(posedge clk_100M); #2;
    s_valid    = 1'b0;
    s_sot      = 1'b0;
    status_clr = 1'b1;
    @(posedge clk_100M); #2;
    status_clr = 1'b0;
  endtask

  // Monitor: each expected word must appear in exactly the cycle it was tagged with.
  always @(negedge clk_100M) begin
    if (sb.size() != 0 && sb[0].tag == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      chk("tdata", m_axis_tdata, e.d);
      chk("tuser", {31'd0, m_axis_tuser}, {31'd0, e.u});
      chk("tlast", {31'd0, m_axis_tlast}, {31'd0, e.l});
    end else begin
      chk("idle_axis", {m_axis_tdata[29:0], m_axis_tvalid, m_axis_tuser | m_axis_tlast},
          32'd0);
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_100M);
    #2;
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_frame_active", {31'd0, frame_active}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_line_count", {16'd0, line_count}, 32'd0);
    chk("rst_errs", {29'd0, ecc_err, len_err, crc_err}, 32'd0);
    reset = 1'b0;

    // Basic frame: FS, one RGB888 line of 8 bytes, FE
    send_hdr(hdr(2'd0, 6'h00, 16'd1), 0);
    idle(1);
    chk("fs_active", {31'd0, frame_active}, 32'd1);
    send_hdr(hdr(2'd0, 6'h24, 16'd8), 1);
    send_pay(32'h0403_0201, 1'b1, 1'b0, 0);
    send_pay(32'h0807_0605, 1'b0, 1'b1, 0);
    send_crc(16'h0000, 0);
    idle(1);
    chk("line1_count", {16'd0, line_count}, 32'd1);
    chk("line1_active", {31'd0, frame_active}, 32'd1);
    send_hdr(hdr(2'd0, 6'h01, 16'd0), 0);
    idle(1);
    chk("fe_active", {31'd0, frame_active}, 32'd0);
    chk("fe_frame_count", {16'd0, frame_count}, 32'd1);
    chk("basic_errs", {29'd0, ecc_err, len_err, crc_err}, 32'd0);

    // Flipped ECC bit: dropped until next s_sot, no output
    send_hdr(hdr(2'd0, 6'h00, 16'd1) ^ 32'h0100_0000, 0);
    drive(32'hDEAD_BEEF, 1'b0, 0);
    drive(32'h0000_0000, 1'b0, 1);
    idle(1);
    chk("ecc_err_set", {31'd0, ecc_err}, 32'd1);
    chk("ecc_fs_ignored", {31'd0, frame_active}, 32'd0);
    clear_flags();
    chk("ecc_err_clr", {31'd0, ecc_err}, 32'd0);

    // RAW10 long packet consumed silently, then a normal FS
    send_hdr(hdr(2'd0, 6'h2B, 16'd12), 0);
    send_skip(32'h1111_1111, 0);
    send_skip(32'h2222_2222, 2);
    send_skip(32'h3333_3333, 0);
    send_crc(16'h0000, 0);
    send_hdr(hdr(2'd0, 6'h00, 16'd1), 0);
    idle(1);
    chk("raw10_fs_active", {31'd0, frame_active}, 32'd1);
    chk("raw10_line_count", {16'd0, line_count}, 32'd0);
    chk("raw10_len_err", {31'd0, len_err}, 32'd0);

    // Illegal word counts
    send_hdr(hdr(2'd0, 6'h24, 16'd6), 0);
    drive(32'h5555_5555, 1'b0, 0);
    idle(1);
    chk("wc6_len_err", {31'd0, len_err}, 32'd1);
    clear_flags();
    chk("wc6_clr", {31'd0, len_err}, 32'd0);
    send_hdr(hdr(2'd0, 6'h24, 16'd7684), 0);
    drive(32'h6666_6666, 1'b0, 0);
    idle(1);
    chk("wc7684_len_err", {31'd0, len_err}, 32'd1);
    clear_flags();

    // Truncation: FE header arrives after 1 of 4 payload words
    send_hdr(hdr(2'd0, 6'h24, 16'd16), 0);
    send_pay(32'hCAFE_0001, 1'b1, 1'b0, 0);
    send_hdr(hdr(2'd0, 6'h01, 16'd0), 0);
    idle(1);
    chk("trunc_len_err", {31'd0, len_err}, 32'd1);
    chk("trunc_line_count", {16'd0, line_count}, 32'd0);
    chk("trunc_fe_active", {31'd0, frame_active}, 32'd0);
    chk("trunc_fe_count", {16'd0, frame_count}, 32'd2);
    clear_flags();

    // Three-line frame with 0-3 cycle gaps
    send_hdr(hdr(2'd0, 6'h00, 16'd2), 0);
    for (int l = 0; l < 3; l++) begin
      send_hdr(hdr(2'd0, 6'h24, 16'd12), l);
      for (int i = 0; i < 3; i++) begin
        send_pay(32'h1000_0000 + 32'(l * 16 + i), (l == 0 && i == 0), (i == 2), (l + i) % 4);
      end
      send_crc(16'h0000, 3 - l);
    end
    send_hdr(hdr(2'd0, 6'h01, 16'd0), 2);
    idle(1);
    chk("frame3_line_count", {16'd0, line_count}, 32'd3);
    chk("frame3_frame_count", {16'd0, frame_count}, 32'd3);
    chk("frame3_errs", {29'd0, ecc_err, len_err, crc_err}, 32'd0);

    // WC==0 long packet expects CRC 0xFFFF; then a corrupted CRC byte
    send_hdr(hdr(2'd0, 6'h24, 16'd0), 0);
    send_crc(16'h0000, 0);
    idle(1);
    chk("wc0_crc_err", {31'd0, crc_err}, 32'd0);
    send_hdr(hdr(2'd0, 6'h24, 16'd8), 0);
    send_pay(32'hA1A2_A3A4, 1'b0, 1'b0, 0);
    send_pay(32'hB1B2_B3B4, 1'b0, 1'b1, 1);
    send_crc(16'h0100, 0);
    idle(1);
    chk("bad_crc_err", {31'd0, crc_err}, {31'd0, EXP_CRC_BAD});
    chk("bad_crc_line_count", {16'd0, line_count}, 32'd4);
    clear_flags();
    chk("crc_err_clr", {31'd0, crc_err}, 32'd0);

    idle(4);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
